// File: rtl/sd_cmd_pkg.sv
// Shared types and default widths for the SD host command master.
package sd_cmd_pkg;

    localparam int unsigned DEF_IDX_W     = 6;
    localparam int unsigned DEF_ARG_W     = 32;
    localparam int unsigned DEF_RESP_W    = 128;
    localparam int unsigned DEF_TO_W      = 16;
    localparam int unsigned DEF_MAX_RETRY = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        WAIT_RESP = 3'd2,
        ACK_WAIT  = 3'd3,
        TIMEOUT   = 3'd4,
        FINISH    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_SHORT = 2'd1;
    localparam logic [1:0] RESP_LONG  = 2'd2;

    // Short and reserved types carry an index to check; none and long do not.
    function automatic logic resp_checks_index(input logic [1:0] rt);
        return (rt != RESP_NONE) && (rt != RESP_LONG);
    endfunction

endpackage

// File: rtl/sd_cmd_master_gen_if.sv
// Host-register and CMD-PHY signal bundle for sd_cmd_master_gen.
interface sd_cmd_master_gen_if
    import sd_cmd_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned ARG_W  = DEF_ARG_W,
    parameter int unsigned RESP_W = DEF_RESP_W,
    parameter int unsigned TO_W   = DEF_TO_W
);
    logic                   new_cmd;
    logic [IDX_W-1:0]       cmd_index;
    logic [ARG_W-1:0]       cmd_arg;
    logic [1:0]             resp_type;
    logic [TO_W-1:0]        timeout_value;
    logic                   REQ_out;
    logic                   ACK_in;
    logic [IDX_W+ARG_W-1:0] cmd_out;
    logic                   REQ_in;
    logic                   ACK_out;
    logic [RESP_W-1:0]      cmd_response;
    logic                   cmd_error;
    logic                   cmd_busy;
    logic                   cmd_complete;
    logic                   timeout_error;
    logic                   cmd_crc_error;
    logic                   cmd_index_error;
    logic [RESP_W-1:0]      response_out;

    modport master (
        input  new_cmd, cmd_index, cmd_arg, resp_type, timeout_value,
        input  ACK_in, REQ_in, cmd_response, cmd_error,
        output REQ_out, cmd_out, ACK_out, cmd_busy, cmd_complete,
        output timeout_error, cmd_crc_error, cmd_index_error, response_out
    );

    modport slave (
        output new_cmd, cmd_index, cmd_arg, resp_type, timeout_value,
        output ACK_in, REQ_in, cmd_response, cmd_error,
        input  REQ_out, cmd_out, ACK_out, cmd_busy, cmd_complete,
        input  timeout_error, cmd_crc_error, cmd_index_error, response_out
    );

endinterface

// File: rtl/sd_cmd_timeout_ctr.sv
// Saturating response-wait counter with a compare-equal hit; a zero limit never hits.
module sd_cmd_timeout_ctr
    import sd_cmd_pkg::*;
#(
    parameter int unsigned TO_W = DEF_TO_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [TO_W-1:0] i_limit,
    output logic            o_hit_c
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_hit_c = (i_limit != '0) && (r_cnt == i_limit);

endmodule

// File: rtl/sd_cmd_master_gen.sv
// SD host command master: issues {index,arg} over REQ/ACK, collects the response, reports status.
// Define SD_CMD_RETRY_EN to re-issue a timed-out command up to MAX_RETRY times.
module sd_cmd_master_gen
    import sd_cmd_pkg::*;
#(
    parameter int unsigned IDX_W     = DEF_IDX_W,
    parameter int unsigned ARG_W     = DEF_ARG_W,
    parameter int unsigned RESP_W    = DEF_RESP_W,
    parameter int unsigned TO_W      = DEF_TO_W
`ifdef SD_CMD_RETRY_EN
   ,parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
`endif
) (
    input  logic                CLK_host,
    input  logic                reset,
    sd_cmd_master_gen_if.master bus
);
    localparam int unsigned CW = IDX_W + ARG_W;

    state_t            r_state;
    logic [1:0]        r_rt;
    logic [TO_W-1:0]   r_to;
    logic [CW-1:0]     r_cmd_out;
    logic              r_req_out;
    logic              r_ack_out;
    logic              r_busy;
    logic              r_complete;
    logic              r_to_err;
    logic              r_crc_err;
    logic              r_idx_err;
    logic [RESP_W-1:0] r_resp;
    logic              w_to_hit;
    logic [IDX_W-1:0]  w_rsp_idx;

`ifdef SD_CMD_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0]  r_retry;
`endif

    assign w_rsp_idx = bus.cmd_response[CW-1:ARG_W];

    // Counter runs only while waiting and is held at zero everywhere else.
    sd_cmd_timeout_ctr #(.TO_W(TO_W)) u_to_ctr (
        .i_clk   (CLK_host),
        .i_rst   (reset),
        .i_clr   (r_state != WAIT_RESP),
        .i_en    (r_state == WAIT_RESP),
        .i_limit (r_to),
        .o_hit_c (w_to_hit)
    );

    always_ff @(posedge CLK_host) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rt       <= RESP_NONE;
            r_to       <= '0;
            r_cmd_out  <= '0;
            r_req_out  <= 1'b0;
            r_ack_out  <= 1'b0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_to_err   <= 1'b0;
            r_crc_err  <= 1'b0;
            r_idx_err  <= 1'b0;
            r_resp     <= '0;
`ifdef SD_CMD_RETRY_EN
            r_retry    <= '0;
`endif
        end else begin
            r_complete <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef SD_CMD_RETRY_EN
                    r_retry <= '0;
`endif
                    if (bus.new_cmd) begin
                        r_rt      <= bus.resp_type;
                        r_to      <= bus.timeout_value;
                        r_cmd_out <= {bus.cmd_index, bus.cmd_arg};
                        r_to_err  <= 1'b0;
                        r_crc_err <= 1'b0;
                        r_idx_err <= 1'b0;
                        r_resp    <= '0;
                        r_busy    <= 1'b1;
                        r_req_out <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.ACK_in) begin
                        r_req_out <= 1'b0;
                        r_state   <= (r_rt == RESP_NONE) ? FINISH : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A response on the compare cycle beats the timeout.
                    if (bus.REQ_in) begin
                        r_resp    <= bus.cmd_response;
                        r_ack_out <= 1'b1;
                        r_crc_err <= bus.cmd_error;
                        if (resp_checks_index(r_rt) && (w_rsp_idx != r_cmd_out[CW-1:ARG_W])) begin
                            r_idx_err <= 1'b1;
                        end
                        r_state   <= ACK_WAIT;
                    end else if (w_to_hit) begin
`ifdef SD_CMD_RETRY_EN
                        if (r_retry < RTY_W'(MAX_RETRY)) begin
                            r_retry   <= r_retry + RTY_W'(1);
                            r_req_out <= 1'b1;
                            r_state   <= SETUP;
                        end else begin
                            r_state   <= TIMEOUT;
                        end
`else
                        r_state <= TIMEOUT;
`endif
                    end
                end
                ACK_WAIT: begin
                    if (!bus.REQ_in) begin
                        r_ack_out <= 1'b0;
                        r_state   <= FINISH;
                    end
                end
                TIMEOUT: begin
                    r_to_err <= 1'b1;
                    r_state  <= FINISH;
                end
                FINISH: begin
                    r_complete <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_out         = r_req_out;
    assign bus.cmd_out         = r_cmd_out;
    assign bus.ACK_out         = r_ack_out;
    assign bus.cmd_busy        = r_busy;
    assign bus.cmd_complete    = r_complete;
    assign bus.timeout_error   = r_to_err;
    assign bus.cmd_crc_error   = r_crc_err;
    assign bus.cmd_index_error = r_idx_err;
    assign bus.response_out    = r_resp;

endmodule

// File: tb/tb_sd_cmd_master_gen.sv
// Bench for sd_cmd_master_gen: directed and random commands against a transaction-level outcome model.
module tb_sd_cmd_master_gen;
    import sd_cmd_pkg::*;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned ARG_W  = 32;
    localparam int unsigned RESP_W = 128;
    localparam int unsigned TO_W   = 16;
    localparam int unsigned CW     = IDX_W + ARG_W;
    localparam int          BUDGET = 400;
`ifdef SD_CMD_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sd_cmd_master_gen_if #(.IDX_W(IDX_W), .ARG_W(ARG_W), .RESP_W(RESP_W), .TO_W(TO_W)) bus ();

    sd_cmd_master_gen #(.IDX_W(IDX_W), .ARG_W(ARG_W), .RESP_W(RESP_W), .TO_W(TO_W)) dut (
        .CLK_host (clk),
        .reset    (rst),
        .bus      (bus)
    );

    typedef struct {
        int                cycles;
        int                hs;
        bit                to_err;
        bit                crc;
        bit                idx_err;
        bit                ack_seen;
        logic [RESP_W-1:0] resp;
    } res_t;

    // Outcome of one command: which attempt answers, resulting flags, and the
    // negedge (counted from the new_cmd negedge) on which cmd_complete shows.
    function automatic res_t model(input logic [1:0] rt, input int tv, input int ack_dly,
                                   input int resp_dly, input int resp_att, input logic err,
                                   input logic [IDX_W-1:0] cidx, input logic [RESP_W-1:0] rsp);
        res_t r;
        int   s;
        r.cycles = 0; r.hs = 0; r.to_err = 0; r.crc = 0; r.idx_err = 0; r.ack_seen = 0; r.resp = '0;
        s = 2 + ack_dly;
        if (rt == RESP_NONE) begin
            r.cycles = s + 1;
            r.hs     = 1;
            return r;
        end
        for (int a = 1; a <= ATTEMPTS; a++) begin
            r.hs = a;
            if (a == resp_att && (tv == 0 || resp_dly <= tv)) begin
                r.cycles   = s + resp_dly + 3;
                r.ack_seen = 1;
                r.resp     = rsp;
                r.crc      = err;
                r.idx_err  = (rt != RESP_LONG) && (rsp[CW-1:ARG_W] != cidx);
                return r;
            end
            if (a == ATTEMPTS) begin
                r.to_err = 1;
                r.cycles = s + tv + 3;
                return r;
            end
            s = s + tv + 2 + ack_dly;
        end
        return r;
    endfunction

    task automatic run_cmd(input string tag, input logic [1:0] rt, input int tv, input int ack_dly,
                           input int resp_dly, input int resp_att, input logic err,
                           input logic [IDX_W-1:0] cidx, input logic [ARG_W-1:0] carg,
                           input logic [RESP_W-1:0] rsp, input bit spurious);
        res_t exp;
        int   c, hi_cnt, hs, k;
        bit   prev_req, pend, active, ack_seen, done, bad_cmd_out;
        logic [2:0] flags;
        logic [RESP_W-1:0] held_resp;
        exp = model(rt, tv, ack_dly, resp_dly, resp_att, err, cidx, rsp);
        @(negedge clk);
        bus.new_cmd       = 1'b1;
        bus.cmd_index     = cidx;
        bus.cmd_arg       = carg;
        bus.resp_type     = rt;
        bus.timeout_value = TO_W'(tv);
        c = 0; hi_cnt = 0; hs = 0; k = 0;
        prev_req = 0; pend = 0; active = 0; ack_seen = 0; done = 0; bad_cmd_out = 0;
        while (c < BUDGET && !done) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                bus.new_cmd = 1'b0;
                n_vec++;
                if ({bus.REQ_out, bus.cmd_busy} !== 2'b11) begin
                    n_err++;
                    $display("FAIL %s start: REQ_out,busy=%b required 11", tag, {bus.REQ_out, bus.cmd_busy});
                end
            end
            if (spurious && c == 2) begin
                bus.new_cmd   = 1'b1;
                bus.cmd_index = ~cidx;
                bus.cmd_arg   = ~carg;
            end
            if (spurious && c == 3) bus.new_cmd = 1'b0;
            if (bus.cmd_complete) begin
                done = 1;
            end else begin
                if (bus.REQ_out) begin
                    if (!prev_req) begin hs++; pend = 0; end
                    if (bus.cmd_out !== {cidx, carg}) bad_cmd_out = 1;
                    if (hi_cnt >= ack_dly) bus.ACK_in = 1'b1;
                    hi_cnt++;
                end else begin
                    if (prev_req && rt != RESP_NONE) begin pend = (hs == resp_att); k = 0; end
                    bus.ACK_in = 1'b0;
                    hi_cnt = 0;
                end
                prev_req = bus.REQ_out;
                if (bus.ACK_out) ack_seen = 1;
                if (pend) begin
                    if (k == resp_dly) begin
                        bus.REQ_in = 1'b1; bus.cmd_response = rsp; bus.cmd_error = err;
                        pend = 0; active = 1;
                    end else begin
                        k++;
                    end
                end else if (active && bus.ACK_out) begin
                    bus.REQ_in = 1'b0; bus.cmd_error = 1'b0; active = 0;
                end
            end
        end
        n_vec++;
        if (c !== exp.cycles) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles required %0d (done=%0d)", tag, c, exp.cycles, done);
        end
        n_vec++;
        if (hs !== exp.hs) begin
            n_err++;
            $display("FAIL %s handshakes: got %0d required %0d", tag, hs, exp.hs);
        end
        flags = {bus.timeout_error, bus.cmd_crc_error, bus.cmd_index_error};
        n_vec++;
        if (flags !== {exp.to_err, exp.crc, exp.idx_err}) begin
            n_err++;
            $display("FAIL %s flags(to,crc,idx): got %b required %b", tag, flags, {exp.to_err, exp.crc, exp.idx_err});
        end
        n_vec++;
        if (bus.response_out !== exp.resp) begin
            n_err++;
            $display("FAIL %s response_out: got %h required %h", tag, bus.response_out, exp.resp);
        end
        n_vec++;
        if ({ack_seen, bus.cmd_busy, bad_cmd_out} !== {exp.ack_seen, 2'b00}) begin
            n_err++;
            $display("FAIL %s ack_seen,busy,cmd_out_bad: got %b required %b", tag,
                     {ack_seen, bus.cmd_busy, bad_cmd_out}, {exp.ack_seen, 2'b00});
        end
        held_resp = bus.response_out;
        bus.REQ_in = 1'b0; bus.ACK_in = 1'b0; bus.cmd_error = 1'b0; bus.new_cmd = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.cmd_complete !== 1'b0 || flags !== {bus.timeout_error, bus.cmd_crc_error, bus.cmd_index_error}
            || bus.response_out !== held_resp) begin
            n_err++;
            $display("FAIL %s hold: complete=%b flags=%b required complete=0 flags=%b",
                     tag, bus.cmd_complete, {bus.timeout_error, bus.cmd_crc_error, bus.cmd_index_error}, flags);
        end
    endtask

    function automatic logic [RESP_W-1:0] mk_rsp(input logic [IDX_W-1:0] ridx);
        logic [RESP_W-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[CW-1:ARG_W] = ridx;
        return r;
    endfunction

    task automatic check_zero(input string tag);
        n_vec++;
        if ({bus.REQ_out, bus.ACK_out, bus.cmd_busy, bus.cmd_complete, bus.timeout_error,
             bus.cmd_crc_error, bus.cmd_index_error} !== 7'b0 || bus.response_out !== '0 || bus.cmd_out !== '0) begin
            n_err++;
            $display("FAIL %s outputs: req,ack,busy,cmp,to,crc,idx=%b cmd_out=%h resp=%h required all 0", tag,
                     {bus.REQ_out, bus.ACK_out, bus.cmd_busy, bus.cmd_complete, bus.timeout_error,
                      bus.cmd_crc_error, bus.cmd_index_error}, bus.cmd_out, bus.response_out);
        end
    endtask

    task automatic check_idle(input string tag);
        bit bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cmd_complete || bus.REQ_out || bus.cmd_busy || bus.ACK_out) bad = 1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s idle after reset: activity seen, required none", tag);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_release");
    endtask

    task automatic test_no_resp();
        run_cmd("none_ack2", RESP_NONE, 0, 2, 0, 0, 1'b0, 6'd0, 32'h0, '0, 0);
        run_cmd("none_ack0", RESP_NONE, 5, 0, 0, 0, 1'b0, 6'd33, 32'hdead_beef, '0, 0);
    endtask

    task automatic test_short_resp();
        run_cmd("short_ok", RESP_SHORT, 20, 1, 3, 1, 1'b0, 6'd17, 32'h0000_0200, mk_rsp(6'd17), 0);
        run_cmd("short_crc", RESP_SHORT, 20, 0, 2, 1, 1'b1, 6'd8, 32'h1234_5678, mk_rsp(6'd8), 0);
        run_cmd("reserved_idx", 2'd3, 20, 0, 1, 1, 1'b0, 6'd17, 32'h1, mk_rsp(6'd4), 0);
    endtask

    task automatic test_index_mismatch();
        run_cmd("short_idx5", RESP_SHORT, 20, 0, 2, 1, 1'b0, 6'd17, 32'h0000_0200, mk_rsp(6'd5), 0);
        run_cmd("long_idx5", RESP_LONG, 20, 0, 2, 1, 1'b0, 6'd17, 32'h0000_0200, mk_rsp(6'd5), 0);
    endtask

    task automatic test_timeout();
        run_cmd("to_10", RESP_SHORT, 10, 0, 0, 0, 1'b0, 6'd2, 32'h5, '0, 0);
        run_cmd("resp_on_compare", RESP_SHORT, 10, 0, 10, 1, 1'b0, 6'd2, 32'h5, mk_rsp(6'd2), 0);
        run_cmd("resp_after_to", RESP_SHORT, 10, 0, 11, 1, 1'b0, 6'd2, 32'h5, mk_rsp(6'd2), 0);
        run_cmd("to_disabled", RESP_LONG, 0, 1, 40, 1, 1'b0, 6'd3, 32'h6, mk_rsp(6'd9), 0);
    endtask

    task automatic test_retry();
`ifdef SD_CMD_RETRY_EN
        run_cmd("retry_exhaust", RESP_SHORT, 6, 1, 0, 0, 1'b0, 6'd11, 32'h77, '0, 0);
        run_cmd("retry_2nd_ok", RESP_SHORT, 6, 0, 2, 2, 1'b0, 6'd11, 32'h77, mk_rsp(6'd11), 0);
`else
        run_cmd("no_retry", RESP_SHORT, 6, 1, 0, 0, 1'b0, 6'd11, 32'h77, '0, 0);
`endif
    endtask

    task automatic test_ignore_new_cmd();
        run_cmd("busy_new_cmd", RESP_SHORT, 15, 1, 4, 1, 1'b0, 6'd21, 32'hcafe_0001, mk_rsp(6'd21), 1);
    endtask

    task automatic test_reset_mid();
        logic [RESP_W-1:0] rsp;
        // Reset while waiting for the response.
        @(negedge clk);
        bus.new_cmd = 1'b1; bus.cmd_index = 6'd9; bus.cmd_arg = 32'h42;
        bus.resp_type = RESP_SHORT; bus.timeout_value = '0;
        @(negedge clk); bus.new_cmd = 1'b0; bus.ACK_in = 1'b1;
        @(negedge clk); bus.ACK_in = 1'b0; rst = 1'b1;
        @(negedge clk); check_zero("rst_wait_resp"); rst = 1'b0;
        check_idle("rst_wait_resp");
        // Reset while holding ACK_out.
        rsp = mk_rsp(6'd9);
        @(negedge clk);
        bus.new_cmd = 1'b1; bus.resp_type = RESP_LONG;
        @(negedge clk); bus.new_cmd = 1'b0; bus.ACK_in = 1'b1;
        @(negedge clk); bus.ACK_in = 1'b0; bus.REQ_in = 1'b1; bus.cmd_response = rsp;
        @(negedge clk);
        n_vec++;
        if (bus.ACK_out !== 1'b1 || bus.response_out !== rsp) begin
            n_err++;
            $display("FAIL rst_ack_wait pre: ACK_out=%b resp=%h required 1 / %h", bus.ACK_out, bus.response_out, rsp);
        end
        rst = 1'b1;
        @(negedge clk); check_zero("rst_ack_wait"); rst = 1'b0; bus.REQ_in = 1'b0;
        check_idle("rst_ack_wait");
        run_cmd("after_reset", RESP_SHORT, 12, 0, 3, 1, 1'b0, 6'd30, 32'h9, mk_rsp(6'd30), 0);
    endtask

    task automatic test_random();
        logic [1:0]       rt;
        logic [IDX_W-1:0] cidx, ridx;
        int               tv, ack_dly, resp_dly, resp_att;
        for (int n = 0; n < 40; n++) begin
            rt       = 2'($urandom_range(0, 3));
            tv       = $urandom_range(0, 12);
            ack_dly  = $urandom_range(0, 3);
            resp_dly = $urandom_range(0, 14);
            resp_att = $urandom_range(0, ATTEMPTS);
            if (tv == 0) resp_att = 1;
            cidx     = IDX_W'($urandom);
            ridx     = ($urandom_range(0, 1) == 1) ? cidx : IDX_W'($urandom);
            run_cmd($sformatf("rand%0d", n), rt, tv, ack_dly, resp_dly, resp_att,
                    1'($urandom_range(0, 1)), cidx, ARG_W'($urandom), mk_rsp(ridx), 0);
        end
    endtask

    initial begin
        bus.new_cmd = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0; bus.resp_type = '0;
        bus.timeout_value = '0; bus.ACK_in = 1'b0; bus.REQ_in = 1'b0;
        bus.cmd_response = '0; bus.cmd_error = 1'b0;
        test_reset();
        test_no_resp();
        test_short_resp();
        test_index_mismatch();
        test_timeout();
        test_retry();
        test_ignore_new_cmd();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
